// File: rtl/o_serdes_ds_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : o_serdes_ds_pkg
//  Description : Shared types, limits and the parameter-legality helper for
//                the multi-channel differential output serializer bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package o_serdes_ds_pkg;

    localparam int MAX_CHANNELS   = 32;
    localparam int MAX_DATA_WIDTH = 16;

    // IDLE: shifter empty, pads at the idle level.
    // SHIFT: a word is being emitted.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Returns 1 when s names a differential pad standard the bank supports.
    function automatic bit iostd_legal(input string s);
        case (s)
            "DEFAULT", "BLVDS_DIFF", "LVDS_HP_DIFF", "LVDS_HR_DIFF",
            "LVPECL_25_DIFF", "LVPECL_33_DIFF", "HSTL_12_DIFF",
            "HSTL_15_DIFF", "HSUL_12_DIFF", "MIPI_DIFF", "POD_12_DIFF",
            "RSDS_DIFF", "SLVS_DIFF", "SSTL_15_DIFF", "SSTL_18_HP_DIFF",
            "SSTL_18_HR_DIFF": return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/o_serdes_ds_lane.sv
`default_nettype none
// ============================================================================
//  Module      : o_serdes_ds_lane
//  Description : One serializer lane: holding register, shift register and
//                registered complementary pad pair with tristate enable.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_accept        - capture i_d into the holding register
//                i_load          - move holding register into the shifter
//                i_step          - emit the next bit of the current word
//                i_oe            - registered pad output enable
//                i_d             - this lane's parallel word
//                o_p / o_n       - differential pad outputs (Z when disabled)
//  Revision    : 1.0 - initial release
// ============================================================================
module o_serdes_ds_lane
    import o_serdes_ds_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 1,
    parameter int IDLE_LEVEL = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_accept,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic                  i_oe,
    input  logic [DATA_WIDTH-1:0] i_d,
    output wire logic             o_p,
    output wire logic             o_n
);

    localparam logic c_idle = (IDLE_LEVEL != 0);

    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_pad_p;
    logic                  r_pad_n;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    // The pad register takes the first bit straight from the holding
    // register on load so the word appears one cycle after transfer; the
    // shifter then only keeps the bits still to be sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold  <= '0;
            r_shift <= '0;
            r_pad_p <= c_idle;
            r_pad_n <= ~c_idle;
        end else begin
            if (i_accept) begin
                r_hold <= i_d;
            end
            if (i_load) begin
                r_shift <= advance(r_hold);
                r_pad_p <= first_bit(r_hold);
                r_pad_n <= ~first_bit(r_hold);
            end else if (i_step) begin
                r_shift <= advance(r_shift);
                r_pad_p <= first_bit(r_shift);
                r_pad_n <= ~first_bit(r_shift);
            end else begin
                r_pad_p <= c_idle;
                r_pad_n <= ~c_idle;
            end
        end
    end

    assign o_p = i_oe ? r_pad_p : 1'bz;
    assign o_n = i_oe ? r_pad_n : 1'bz;

endmodule
`default_nettype wire

// File: rtl/o_serdes_ds_bank.sv
`default_nettype none
// ============================================================================
//  Module      : o_serdes_ds_bank
//  Description : Multi-channel differential output serializer. Accepts one
//                word per lane via valid/ready, double-buffers it and shifts
//                it out one bit per clock on complementary pad pairs.
//  Ports       : CLK, RST            - clock, synchronous active-high reset
//                D, DATA_VALID       - parallel words, lane k at k*DATA_WIDTH
//                DATA_READY          - bank accepts a word this cycle
//                OE                  - pad enable, takes effect one cycle later
//                BUSY                - shifter or holding register occupied
//                UNDERRUN            - one-cycle pulse when streaming starves
//                O_P, O_N            - differential pad outputs per lane
//  Revision    : 1.0 - initial release
// ============================================================================
module o_serdes_ds_bank
    import o_serdes_ds_pkg::*;
#(
    parameter int    NUM_CHANNELS             = 4,
    parameter int    DATA_WIDTH               = 8,
    parameter int    MSB_FIRST                = 1,
    parameter int    IDLE_LEVEL               = 0,
    parameter string IOSTANDARD               = "DEFAULT",
    parameter string DIFFERENTIAL_TERMINATION = "TRUE"
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] D,
    input  logic                               DATA_VALID,
    output logic                               DATA_READY,
    input  logic                               OE,
    output logic                               BUSY,
    output logic                               UNDERRUN,
    output wire logic [NUM_CHANNELS-1:0]       O_P,
    output wire logic [NUM_CHANNELS-1:0]       O_N
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    if (!iostd_legal(IOSTANDARD) ||
        !(DIFFERENTIAL_TERMINATION == "TRUE" || DIFFERENTIAL_TERMINATION == "FALSE") ||
        NUM_CHANNELS < 1 || NUM_CHANNELS > MAX_CHANNELS ||
        DATA_WIDTH < 2 || DATA_WIDTH > MAX_DATA_WIDTH ||
        !(MSB_FIRST == 0 || MSB_FIRST == 1) ||
        !(IDLE_LEVEL == 0 || IDLE_LEVEL == 1)) begin : g_bad_param
        $fatal(1, "%m: illegal parameter (IOSTANDARD/DIFFERENTIAL_TERMINATION/NUM_CHANNELS/DATA_WIDTH/MSB_FIRST/IDLE_LEVEL)");
    end

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic          r_hold_full;
    logic          r_underrun;
    logic          r_oe_q;

    logic          w_last;
    logic          w_load;
    logic          w_accept;
    logic          w_step;
    logic          w_starve;

    assign w_last   = (r_cnt == CW'(DATA_WIDTH - 1));
    assign w_load   = ((r_state == IDLE) || w_last) && r_hold_full;
    // A word can be taken in the same cycle the holding register empties.
    assign DATA_READY = !RST && (!r_hold_full || w_load);
    assign w_accept = DATA_VALID && DATA_READY;
    assign w_step   = (r_state == SHIFT) && !w_last;
    assign w_starve = (r_state == SHIFT) && w_last && !r_hold_full;

    always_comb begin
        w_state_next = r_state;
        if (w_load) begin
            w_state_next = SHIFT;
        end else if (w_starve) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hold_full <= 1'b0;
            r_underrun  <= 1'b0;
            r_oe_q      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_underrun <= w_starve;
            r_oe_q     <= OE;
            if (w_accept) begin
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign BUSY     = (r_state == SHIFT) || r_hold_full;
    assign UNDERRUN = r_underrun;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
        o_serdes_ds_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .MSB_FIRST  (MSB_FIRST),
            .IDLE_LEVEL (IDLE_LEVEL)
        ) u_lane (
            .clk      (CLK),
            .rst      (RST),
            .i_accept (w_accept),
            .i_load   (w_load),
            .i_step   (w_step),
            .i_oe     (r_oe_q),
            .i_d      (D[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_p      (O_P[g]),
            .o_n      (O_N[g])
        );
    end

`ifdef TIMED_SIM
    specify
        (CLK *> O_P) = 0.5;
        (CLK *> O_N) = 0.5;
    endspecify
`endif

endmodule
`default_nettype wire

// File: tb/tb_o_serdes_ds_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_o_serdes_ds_bank
//  Description : Directed self-checking bench for o_serdes_ds_bank with two
//                8-bit lanes, MSB first, idle level 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_o_serdes_ds_bank;

    localparam int NCH = 2;
    localparam int DW  = 8;

    logic              clk;
    logic              rst;
    logic [NCH*DW-1:0] d;
    logic              dv;
    logic              oe;
    logic              data_ready;
    logic              busy;
    logic              underrun;
    wire  [NCH-1:0]    o_p;
    wire  [NCH-1:0]    o_n;

    int n_total = 0;
    int n_bad   = 0;

    o_serdes_ds_bank #(
        .NUM_CHANNELS             (NCH),
        .DATA_WIDTH               (DW),
        .MSB_FIRST                (1),
        .IDLE_LEVEL               (0),
        .IOSTANDARD               ("LVDS_HP_DIFF"),
        .DIFFERENTIAL_TERMINATION ("TRUE")
    ) u_dut (
        .CLK        (clk),
        .RST        (rst),
        .D          (d),
        .DATA_VALID (dv),
        .DATA_READY (data_ready),
        .OE         (oe),
        .BUSY       (busy),
        .UNDERRUN   (underrun),
        .O_P        (o_p),
        .O_N        (o_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Sends one word per lane from an idle bank and checks every bit plus
    // the trailing underrun pulse.
    task automatic run_word(input logic [7:0] a, input logic [7:0] b);
        logic [1:0] ep;
        logic [1:0] en;
        d  = {b, a};
        dv = 1'b1;
        chk("w_ready", data_ready, 1);
        tick;
        dv = 1'b0;
        d  = '0;
        chk("w_busy", busy, 1);
        chk("w_pre_idle", o_p, 2'b00);
        for (int j = 0; j < 8; j++) begin
            tick;
            ep = {b[7-j], a[7-j]};
            en = ~ep;
            chk("w_op", o_p, ep);
            chk("w_on", o_n, en);
            chk("w_no_ur", underrun, 0);
            chk("w_busy_sh", busy, 1);
        end
        tick;
        chk("w_ur", underrun, 1);
        chk("w_ur_op", o_p, 2'b00);
        chk("w_ur_on", o_n, 2'b11);
        chk("w_ur_busy", busy, 0);
        tick;
        chk("w_ur_end", underrun, 0);
    endtask

    logic [7:0] s0 [3];
    logic [7:0] s1 [3];
    logic [7:0] wa;
    logic [7:0] wb;
    logic [1:0] ep;
    logic [1:0] en;

    initial begin
        s0[0] = 8'h01; s0[1] = 8'h80; s0[2] = 8'hFF;
        s1[0] = 8'hFE; s1[1] = 8'h7F; s1[2] = 8'h00;

        // ---------------- reset ----------------
        rst = 1'b1; dv = 1'b1; d = 16'hFFFF; oe = 1'b0;
        tick; tick; tick;
        chk("rst_ready", data_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ur", underrun, 0);
        chk("rst_pz", (o_p === 2'bzz), 1);
        chk("rst_nz", (o_n === 2'bzz), 1);
        rst = 1'b0; dv = 1'b0; d = '0; oe = 1'b1;
        tick;
        chk("idle_op", o_p, 2'b00);
        chk("idle_on", o_n, 2'b11);
        chk("idle_ready", data_ready, 1);

        // ---------------- single word ----------------
        run_word(8'hA5, 8'h3C);

        // ---------------- streaming ----------------
        d = {s1[0], s0[0]}; dv = 1'b1;
        chk("st_rdy0", data_ready, 1);
        tick;
        d = {s1[1], s0[1]};
        chk("st_rdy1", data_ready, 1);
        tick;
        d = {s1[2], s0[2]};
        for (int b = 0; b < 24; b++) begin
            wa = s0[b/8];
            wb = s1[b/8];
            ep = {wb[7-(b%8)], wa[7-(b%8)]};
            en = ~ep;
            chk("st_op", o_p, ep);
            chk("st_on", o_n, en);
            chk("st_no_ur", underrun, 0);
            chk("st_ready", data_ready, (b == 7 || b >= 15) ? 1 : 0);
            tick;
            if (b == 7) begin
                dv = 1'b0;
                d  = '0;
            end
        end
        chk("st_ur", underrun, 1);
        chk("st_ur_op", o_p, 2'b00);
        tick;

        // ---------------- OE toggle mid-word ----------------
        wa = 8'hC3; wb = 8'h5A;
        d = {wb, wa}; dv = 1'b1;
        tick;
        dv = 1'b0; d = '0;
        for (int j = 0; j < 8; j++) begin
            tick;
            ep = {wb[7-j], wa[7-j]};
            en = ~ep;
            if (j >= 4 && j <= 6) begin
                chk("oe_pz", (o_p === 2'bzz), 1);
                chk("oe_nz", (o_n === 2'bzz), 1);
            end else begin
                chk("oe_op", o_p, ep);
                chk("oe_on", o_n, en);
            end
            chk("oe_busy", busy, 1);
            if (j == 3) oe = 1'b0;
            if (j == 6) oe = 1'b1;
        end
        tick;
        chk("oe_ur", underrun, 1);
        tick;

        // ---------------- reset mid-word ----------------
        d = {8'h69, 8'h96}; dv = 1'b1;
        tick;
        d = {8'h0F, 8'hF0};
        chk("rm_rdy_q", data_ready, 1);
        tick;
        dv = 1'b0; d = '0;
        chk("rm_bit0", o_p, 2'b01);
        tick; tick; tick; tick;
        chk("rm_bit4", o_p, 2'b10);
        chk("rm_busy_pre", busy, 1);
        rst = 1'b1;
        tick;
        chk("rm_busy", busy, 0);
        chk("rm_pz", (o_p === 2'bzz), 1);
        chk("rm_nz", (o_n === 2'bzz), 1);
        chk("rm_ur", underrun, 0);
        chk("rm_ready", data_ready, 0);
        rst = 1'b0;
        tick;
        chk("rm_idle_op", o_p, 2'b00);
        chk("rm_idle_on", o_n, 2'b11);
        chk("rm_idle_busy", busy, 0);
        chk("rm_idle_ur", underrun, 0);
        run_word(8'h2D, 8'hD2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
